// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_queue
// Description : Circular instruction queue between fetch and decode. Accepts
//               packets of up to FETCH_W instructions, presents up to ISSUE_W
//               oldest entries per cycle with PC and predecode flags.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_queue #(
    parameter  int FETCH_W        = 2,
    parameter  int ISSUE_W        = 2,
    parameter  int DEPTH          = 8,
    parameter  bit STOP_AT_BRANCH = 1'b1,
    localparam int CW_F           = $clog2(FETCH_W + 1),
    localparam int CW_I           = $clog2(ISSUE_W + 1),
    localparam int CW_D           = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CW_F-1:0]         in_count,
    input  logic [31:0]             in_pc,
    input  logic [32*FETCH_W-1:0]   in_instr,
    output logic [ISSUE_W-1:0]      out_valid,
    output logic [32*ISSUE_W-1:0]   out_instr,
    output logic [32*ISSUE_W-1:0]   out_pc,
    output logic [ISSUE_W-1:0]      out_branch,
    output logic [ISSUE_W-1:0]      out_link,
    output logic [ISSUE_W-1:0]      out_udf,
    input  logic [CW_I-1:0]         out_take,
    output logic [CW_D-1:0]         count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]     r_instr [DEPTH];
    logic [31:0]     r_pc    [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW_D-1:0] r_count;

    logic            w_enq;
    logic [ISSUE_W-1:0] w_in_range;
    logic [ISSUE_W-1:0] w_br;
    logic [ISSUE_W-1:0] w_lk;
    logic [ISSUE_W-1:0] w_ud;

    // Returns {udf, link, branch}; branch and link are suppressed on udf.
    function automatic logic [2:0] predecode(input logic [31:0] ins);
        logic [5:0] op;
        logic       udf;
        logic       br;
        logic       lnk;
        op  = ins[5:0];
        udf = 1'b0;
        if (op[5:3] == 3'b000) udf = 1'b1;
        if (op[5:4] == 2'b11) begin
            case (op[3:0])
                4'h0, 4'h1, 4'h8, 4'h9, 4'hB, 4'hD, 4'hE: ;
                default: udf = 1'b1;
            endcase
        end
        if (op == 6'h3D) begin
            case (ins[15:11])
                5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7: ;
                default: udf = 1'b1;
            endcase
        end
        if (op == 6'h3E && ins[31:27] != 5'h00 && ins[31:27] != 5'h1F) udf = 1'b1;
        br  = (op[5:3] == 3'b001) || (op == 6'h38 && ins[10]);
        lnk = (op[5:3] == 3'b001 && op[2:0] == 3'b111) ||
              (op == 6'h38 && ins[10] && ins[6]);
        return {udf, lnk & ~udf, br & ~udf};
    endfunction

    // Readiness is based on registered occupancy only; a same-cycle dequeue
    // does not open space for the incoming packet.
    assign in_ready = (32'(r_count) <= 32'(DEPTH - FETCH_W));
    assign w_enq    = in_valid && in_ready && !flush;
    assign count    = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + AW'(in_count);
            end
            r_head  <= r_head + AW'(out_take);
            r_count <= r_count + (w_enq ? CW_D'(in_count) : CW_D'(0)) - CW_D'(out_take);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (i < int'(in_count)) begin
                    r_instr[r_tail + AW'(i)] <= in_instr[32*i +: 32];
                    r_pc[r_tail + AW'(i)]    <= in_pc + 32'(4 * i);
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
            logic [AW-1:0] w_idx;
            logic [2:0]    w_pd;
            assign w_idx                  = r_head + AW'(g);
            assign out_instr[32*g +: 32]  = r_instr[w_idx];
            assign out_pc[32*g +: 32]     = r_pc[w_idx];
            assign w_pd                   = predecode(r_instr[w_idx]);
            assign w_br[g]                = w_pd[0];
            assign w_lk[g]                = w_pd[1];
            assign w_ud[g]                = w_pd[2];
            assign w_in_range[g]          = (32'(g) < 32'(r_count));
        end
    endgenerate

    // Lanes beyond the first branch are withheld so a group holds at most one.
    always_comb begin
        logic w_seen;
        w_seen    = 1'b0;
        out_valid = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            out_valid[i] = w_in_range[i] && !(STOP_AT_BRANCH && w_seen);
            if (w_in_range[i] && w_br[i]) w_seen = 1'b1;
        end
    end

    assign out_branch = w_br & out_valid;
    assign out_link   = w_lk & out_valid;
    assign out_udf    = w_ud & out_valid;

    a_take_legal: assert property (@(posedge clk) disable iff (rst)
        32'(out_take) <= 32'($countones(out_valid)));

    a_count_legal: assert property (@(posedge clk) disable iff (rst)
        (in_valid && in_ready && !flush) |-> (in_count != '0 && 32'(in_count) <= 32'(FETCH_W)));

endmodule
`default_nettype wire
